// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register peripheral.
// Holds the register address map, the frame field widths, the bit-count
// thresholds and the frame-state enum used by spi_peripheral.
package spi_regs_pkg;

  // Frame layout: [15] = R/W (1 = write), [14:8] = address, [7:0] = data
  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  // Register address map (the five registers feeding the PWM stage)
  localparam int ADDR_EN_OUT_LO = 'h00;
  localparam int ADDR_EN_OUT_HI = 'h01;
  localparam int ADDR_PWM_LO    = 'h02;
  localparam int ADDR_PWM_HI    = 'h03;
  localparam int ADDR_PWM_DUTY  = 'h04;

  // Bit counter thresholds
  localparam logic [4:0] BIT_CNT_HDR  = 5'd8;   // R/W + address received
  localparam logic [4:0] BIT_CNT_FULL = 5'd16;  // complete frame
  localparam logic [4:0] BIT_CNT_MAX  = 5'd17;  // saturation point

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous pad input.
// Parameters: DEPTH   - number of flops in the chain (2..3)
//             RST_VAL - value every flop takes while rst_n is low
// Ports:      clk   - system clock
//             rst_n - asynchronous active-low reset
//             d     - asynchronous input
//             q     - synchronized output
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {DEPTH{RST_VAL}};
    end else begin
      chain_q <= {chain_q[DEPTH-2:0], d};
    end
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI (mode 0) write-register peripheral feeding a PWM stage.
// A 16-bit frame {R/W, addr[6:0], data[7:0]} is shifted in MSB first on
// sclk rising edges while ncs is low; on ncs rising the frame is committed
// to the addressed register if it is a complete, legal write.
//
// Optional feature macro: SPI_READBACK_EN
//   defined   - read frames (R/W = 0) return the addressed register on cipo
//               during data bits 7..0; cipo_oe is high while shifting.
//   undefined - cipo and cipo_oe are tied low, read frames are ignored.
//
// Parameters: SYNC_STAGES - synchronizer depth per pad input (2..3)
//             NUM_REGS    - implemented register addresses 0..NUM_REGS-1
// Ports:      clk, rst_n  - system clock, async active-low reset
//             sclk, copi, ncs - SPI pad inputs (asynchronous to clk)
//             cipo, cipo_oe   - SPI read data and its output enable
//             en_reg_out_7_0 .. pwm_duty_cycle - registers 0x00..0x04
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  // The five output registers always exist; extra addresses are storage only
  localparam int REG_DEPTH = (NUM_REGS > 5) ? NUM_REGS : 5;

  logic sclk_s, copi_s, ncs_s;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (copi),
    .q     (copi_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ncs),
    .q     (ncs_s)
  );

  // Edge detection on synchronized values
  logic sclk_q, ncs_q;
  logic sclk_rise, ncs_fall, ncs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      ncs_q  <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      ncs_q  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = ncs_q & ~ncs_s;
  assign ncs_rise  = ~ncs_q & ncs_s;

  // Frame FSM
  spi_state_t state_q, state_d;
  logic       start_frame;
  logic       shift_en;
  logic       commit;
  logic       pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A falling ncs seen during COMMIT is remembered in pend_q
        if (ncs_fall || (pend_q && !ncs_s)) begin
          state_d     = ST_SHIFT;
          start_frame = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Sampling happens even when ncs rises in the same cycle
        shift_en = sclk_rise;
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (start_frame) begin
      pend_q <= 1'b0;
    end else if ((state_q == ST_COMMIT) && ncs_fall) begin
      pend_q <= 1'b1;
    end
  end

  // Shift register and saturating bit counter
  logic [FRAME_W-1:0] shift_q;
  logic [4:0]         bit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (start_frame) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME_W-2:0], copi_s};
      if (bit_cnt_q != BIT_CNT_MAX) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
    end
  end

  // Frame decode and register commit
  logic              frame_wr;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              wr_hit;

  assign frame_wr   = shift_q[FRAME_W-1];
  assign frame_addr = shift_q[FRAME_W-2:DATA_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign wr_hit     = commit && (bit_cnt_q == BIT_CNT_FULL) && frame_wr &&
                      (int'(frame_addr) < NUM_REGS);

  logic [DATA_W-1:0] regs_q [REG_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        if (int'(frame_addr) == i) begin
          regs_q[i] <= frame_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];

`ifdef SPI_READBACK_EN
  // Readback: after 8 bits the header sits in shift_q[7:0]; the addressed
  // register is loaded on the next sclk falling edge so its MSB is valid
  // before the 9th rising edge, then shifted out on each later falling edge.
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_q;
  logic              oe_q;

  assign sclk_fall = ~sclk_s & sclk_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(shift_q[ADDR_W-1:0]) == i) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      oe_q <= 1'b0;
    end else begin
      oe_q <= (state_d == ST_SHIFT);
      if (state_q != ST_SHIFT) begin
        tx_q <= '0;
      end else if (sclk_fall) begin
        if (bit_cnt_q == BIT_CNT_HDR) begin
          tx_q <= shift_q[DATA_W-1] ? '0 : rd_data;
        end else if ((bit_cnt_q > BIT_CNT_HDR) && (bit_cnt_q < BIT_CNT_FULL)) begin
          tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign cipo    = tx_q[DATA_W-1];
  assign cipo_oe = oe_q;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
module tb_spi_peripheral;

  localparam int SYNC = 2;
  localparam int NREG = 5;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic       cipo_oe;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  spi_peripheral #(.SYNC_STAGES(SYNC), .NUM_REGS(NREG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .cipo_oe         (cipo_oe),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents as the protocol rules dictate
  logic [7:0] exp_regs [NREG];

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
  endfunction

  function automatic void model_frame(input logic [15:0] w, input int nbits);
    int a;
    a = int'(w[14:8]);
    if (nbits == 16 && w[15] && a < NREG) exp_regs[a] = w[7:0];
  endfunction

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  // Monitors
  logic       mon_on = 1'b0;
  logic [7:0] mon_last = 8'h00;
  logic [7:0] mon_q [$];
  logic       cc_seen = 1'b0;
  logic       oe_seen = 1'b0;
  logic       cipo_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_on && pwm_duty_cycle !== mon_last) begin
      mon_q.push_back(pwm_duty_cycle);
      mon_last = pwm_duty_cycle;
    end
    if (!mon_on) mon_last = pwm_duty_cycle;
    if (en_reg_pwm_15_8 === 8'hCC) cc_seen = 1'b1;
    if (cipo_oe === 1'b1) oe_seen = 1'b1;
    if (cipo === 1'b1) cipo_seen = 1'b1;
  end

  // SPI mode-0 controller: drives nbits of w MSB first, half = sclk half
  // period in ns; rx collects cipo during the high phase of bits 8..15.
  task automatic spi_xfer(input logic [15:0] w, input int nbits, input int half,
                          input bit release_ncs, output logic [7:0] rx);
    rx  = 8'h00;
    ncs = 1'b0;
    #(half);
    for (int i = 0; i < nbits; i++) begin
      copi = w[15-i];
      #(half);
      sclk = 1'b1;
      #(half - 2);
      if (i >= 8) rx = {rx[6:0], cipo};
      #2;
      sclk = 1'b0;
    end
    copi = 1'b0;
    #(half);
    if (release_ncs) ncs = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    model_reset();
    #23;
    checks++;
    if (cipo !== 1'b0) begin errors++; $display("FAIL reset_cipo got %b want 0", cipo); end
    checks++;
    if (cipo_oe !== 1'b0) begin errors++; $display("FAIL reset_cipo_oe got %b want 0", cipo_oe); end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL reset_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
    #4 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #3;
  endtask

  task automatic test_basic_write();
    logic [7:0] rx;
    spi_xfer(16'h80F0, 16, 40, 1'b1, rx);
    model_frame(16'h80F0, 16);
    repeat (SYNC + 3) @(posedge clk);
    #1;
    checks++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      errors++; $display("FAIL basic_latency got %h want f0", en_reg_out_7_0);
    end
    repeat (6) @(posedge clk);
    #3;
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL basic_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    mon_q.delete();
    mon_on = 1'b1;
    spi_xfer(16'h8480, 16, 40, 1'b1, rx);
    model_frame(16'h8480, 16);
    repeat (6) @(posedge clk);
    #3;
    spi_xfer(16'h84FF, 16, 40, 1'b1, rx);
    model_frame(16'h84FF, 16);
    repeat (10) @(posedge clk);
    #3;
    mon_on = 1'b0;
    checks++;
    if (mon_q.size() != 2) begin
      errors++; $display("FAIL b2b_num_changes got %0d want 2", mon_q.size());
    end else begin
      checks++;
      if (mon_q[0] !== 8'h80) begin errors++; $display("FAIL b2b_first got %h want 80", mon_q[0]); end
      checks++;
      if (mon_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", mon_q[1]); end
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL b2b_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] rx;
    spi_xfer(16'hB0AA, 16, 40, 1'b1, rx);
    model_frame(16'hB0AA, 16);
    repeat (10) @(posedge clk);
    #3;
    spi_xfer(16'h815A, 15, 40, 1'b1, rx);
    model_frame(16'h815A, 15);
    repeat (10) @(posedge clk);
    #3;
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL illegal_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] rx;
`ifdef SPI_READBACK_EN
    spi_xfer(16'h82A5, 16, 40, 1'b1, rx);
    model_frame(16'h82A5, 16);
    repeat (10) @(posedge clk);
    #3;
    oe_seen = 1'b0;
    spi_xfer(16'h0200, 16, 40, 1'b1, rx);
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (rx !== exp_regs[2]) begin errors++; $display("FAIL read_data got %h want %h", rx, exp_regs[2]); end
    checks++;
    if (oe_seen !== 1'b1) begin errors++; $display("FAIL read_oe got %b want 1", oe_seen); end
    oe_seen = 1'b0;
    spi_xfer(16'h3000, 16, 40, 1'b1, rx);
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (rx !== 8'h00) begin errors++; $display("FAIL read_oob got %h want 00", rx); end
`else
    oe_seen   = 1'b0;
    cipo_seen = 1'b0;
    spi_xfer(16'h0200, 16, 40, 1'b1, rx);
    model_frame(16'h0200, 16);
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL read_oe got %b want 0", oe_seen); end
    checks++;
    if (cipo_seen !== 1'b0) begin errors++; $display("FAIL read_cipo got %b want 0", cipo_seen); end
`endif
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL read_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    cc_seen = 1'b0;
    spi_xfer(16'h83CC, 9, 40, 1'b0, rx);
    #7 rst_n = 1'b0;
    model_reset();
    #30 ncs = 1'b1;
    #30 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dut_reg(i) !== exp_regs[i]) begin
        errors++; $display("FAIL midrst_reg%0d got %h want %h", i, dut_reg(i), exp_regs[i]);
      end
    end
    spi_xfer(16'h8311, 16, 40, 1'b1, rx);
    model_frame(16'h8311, 16);
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (en_reg_pwm_15_8 !== 8'h11) begin
      errors++; $display("FAIL midrst_write got %h want 11", en_reg_pwm_15_8);
    end
    checks++;
    if (cc_seen !== 1'b0) begin errors++; $display("FAIL midrst_partial got cc_seen=%b want 0", cc_seen); end
  endtask

  task automatic test_random();
    logic [7:0]  rx;
    logic [15:0] w;
    int          half;
    for (int n = 0; n < 20; n++) begin
      w    = {1'b1, 7'($urandom_range(0, NREG - 1)), 8'($urandom_range(0, 255))};
      half = $urandom_range(40, 70);
      #($urandom_range(0, 9));
      spi_xfer(w, 16, half, 1'b1, rx);
      model_frame(w, 16);
      repeat (10) @(posedge clk);
      #($urandom_range(1, 4));
      for (int i = 0; i < NREG; i++) begin
        checks++;
        if (dut_reg(i) !== exp_regs[i]) begin
          errors++;
          $display("FAIL random%0d_reg%0d frame %h got %h want %h", n, i, w, dut_reg(i), exp_regs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_illegal();
    test_read();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
